// File: rtl/oai21_tt_checker.sv
// oai21_tt_checker: sweeps all eight {B,A2,A1} vectors into an OAI21 cell,
// waits SETTLE cycles per vector, samples ZN and compares it with EXPECT.
// Results (pass, error count, first failing vector) are reported through
// a start/busy/done handshake.
//
// state  | meaning
// IDLE   | stimulus held at 0, waiting for START
// APPLY  | vector idx driven, settle counter runs 0..SETTLE-1
// SAMPLE | one cycle, ZN compared with EXPECT[idx]
// FINISH | one cycle, DONE high, PASS updated, then back to IDLE
module oai21_tt_checker #(
    parameter logic [7:0] EXPECT = 8'h1F,
    parameter int         SETTLE = 2,
    parameter int         CNT_W  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [2:0]       FAIL_IDX,
    output logic             FAIL_VLD
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [3:0]       settle_cnt, settle_cnt_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [2:0]       fail_idx_nxt;
    logic             fail_vld_nxt;
    logic             pass_nxt;
    logic             mismatch;

    // X or Z on the cell output must count as a failure, hence the case-inequality.
    assign mismatch = (ZN !== EXPECT[idx]);

    // Stimulus only leaves 000 while a vector is being exercised.
    assign {B, A2, A1} = (state == APPLY || state == SAMPLE) ? idx : 3'b000;
    assign BUSY        = (state == APPLY || state == SAMPLE);
    assign DONE        = (state == FINISH);

    // State and result registers; synchronous reset clears everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            ERR_CNT    <= '0;
            FAIL_IDX   <= 3'd0;
            FAIL_VLD   <= 1'b0;
            PASS       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            settle_cnt <= settle_cnt_nxt;
            ERR_CNT    <= err_cnt_nxt;
            FAIL_IDX   <= fail_idx_nxt;
            FAIL_VLD   <= fail_vld_nxt;
            PASS       <= pass_nxt;
        end
    end

    // Next-state and result update logic for the sweep sequencer.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        settle_cnt_nxt = settle_cnt;
        err_cnt_nxt    = ERR_CNT;
        fail_idx_nxt   = FAIL_IDX;
        fail_vld_nxt   = FAIL_VLD;
        pass_nxt       = PASS;

        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt      = APPLY;
                    idx_nxt        = 3'd0;
                    settle_cnt_nxt = 4'd0;
                    err_cnt_nxt    = '0;
                    fail_idx_nxt   = 3'd0;
                    fail_vld_nxt   = 1'b0;
                    pass_nxt       = 1'b0;
                end
            end
            APPLY: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_cnt_nxt = ERR_CNT + CNT_ONE;
                    if (!FAIL_VLD) begin
                        fail_idx_nxt = idx;
                        fail_vld_nxt = 1'b1;
                    end
                end
                if (idx == 3'd7) begin
                    // PASS must reflect any error found on this final vector.
                    state_nxt = FINISH;
                    pass_nxt  = (err_cnt_nxt == '0);
                end else begin
                    state_nxt      = APPLY;
                    idx_nxt        = idx + 3'd1;
                    settle_cnt_nxt = 4'd0;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oai21_tt_checker.sv
// Bench for oai21_tt_checker: two instances (SETTLE=2 and SETTLE=1) each
// driving a behavioural OAI21 cell with injectable faults.
module tb_oai21_tt_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       zn    [2];
    logic       a1    [2];
    logic       a2    [2];
    logic       b     [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [3:0] err   [2];
    logic [2:0] fidx  [2];
    logic       fvld  [2];

    logic [7:0] flip [2];
    logic       xen  [2];
    logic [2:0] xidx [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    oai21_tt_checker #(.EXPECT(8'h1F), .SETTLE(2), .CNT_W(4)) dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .ZN(zn[0]),
        .A1(a1[0]), .A2(a2[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]),
        .PASS(pass[0]), .ERR_CNT(err[0]), .FAIL_IDX(fidx[0]), .FAIL_VLD(fvld[0])
    );

    oai21_tt_checker #(.EXPECT(8'h1F), .SETTLE(1), .CNT_W(4)) dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .ZN(zn[1]),
        .A1(a1[1]), .A2(a2[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]),
        .PASS(pass[1]), .ERR_CNT(err[1]), .FAIL_IDX(fidx[1]), .FAIL_VLD(fvld[1])
    );

    // Behavioural cell: ideal OAI21, optionally inverted per vector or forced to X.
    function automatic logic cell_zn(input logic [2:0] v, input logic [7:0] fl,
                                     input logic xe, input logic [2:0] xi);
        logic good;
        good = !((v[0] | v[1]) & v[2]);
        if (xe && v == xi) return 1'bx;
        return good ^ fl[v];
    endfunction

    always_comb zn[0] = cell_zn({b[0], a2[0], a1[0]}, flip[0], xen[0], xidx[0]);
    always_comb zn[1] = cell_zn({b[1], a2[1], a1[1]}, flip[1], xen[1], xidx[1]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sweep on instance s; expected results come from the fault set.
    task automatic run_sweep(input int s, input logic [7:0] fl, input logic xe,
                             input logic [2:0] xi, input bit inj, input string tag);
        int         st;
        int         bc;
        int         dc;
        int         win;
        logic [7:0] mm;
        int         e_err;
        int         e_first;
        st  = (s == 0) ? 2 : 1;
        win = 8 * (st + 1) + 6;
        flip[s] = fl;
        xen[s]  = xe;
        xidx[s] = xi;
        mm = fl | (xe ? (8'd1 << xi) : 8'd0);
        e_err   = $countones(mm);
        e_first = 0;
        for (int i = 7; i >= 0; i--) if (mm[i]) e_first = i;
        bc = 0;
        dc = 0;
        @(negedge clk);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        for (int n = 0; n < win; n++) begin
            if (busy[s]) begin
                check({tag, "_stim"}, 32'({b[s], a2[s], a1[s]}), 32'(bc / (st + 1)));
                bc++;
            end else begin
                check({tag, "_stim_idle"}, 32'({b[s], a2[s], a1[s]}), 32'd0);
            end
            if (done[s]) begin
                dc++;
                check({tag, "_pass"},     32'(pass[s]), 32'(mm == 8'd0));
                check({tag, "_err_cnt"},  32'(err[s]),  32'(e_err));
                check({tag, "_fail_idx"}, 32'(fidx[s]), 32'(e_first));
                check({tag, "_fail_vld"}, 32'(fvld[s]), 32'(mm != 8'd0));
            end
            start[s] = inj && (n == 2 || n == 14 || done[s]);
            @(negedge clk);
        end
        start[s] = 1'b0;
        check({tag, "_busy_cycles"}, 32'(bc), 32'(8 * (st + 1)));
        check({tag, "_done_count"},  32'(dc), 32'd1);
        check({tag, "_err_hold"},    32'(err[s]),  32'(e_err));
        check({tag, "_pass_hold"},   32'(pass[s]), 32'(mm == 8'd0));
    endtask

    initial begin
        int         bc;
        int         dc;
        logic [7:0] r;
        rst      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = 8'd0;
            xen[i]  = 1'b0;
            xidx[i] = 3'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check("reset_stim",     32'({b[i], a2[i], a1[i]}), 32'd0);
            check("reset_busy",     32'(busy[i]), 32'd0);
            check("reset_done",     32'(done[i]), 32'd0);
            check("reset_pass",     32'(pass[i]), 32'd0);
            check("reset_err",      32'(err[i]),  32'd0);
            check("reset_fail_idx", 32'(fidx[i]), 32'd0);
            check("reset_fail_vld", 32'(fvld[i]), 32'd0);
        end

        run_sweep(0, 8'h00, 1'b0, 3'd0, 1'b0, "good");
        run_sweep(0, 8'h20, 1'b0, 3'd0, 1'b0, "stuck5");
        run_sweep(0, 8'h1F, 1'b0, 3'd0, 1'b0, "tied0");
        run_sweep(0, 8'h00, 1'b0, 3'd0, 1'b0, "good_rerun");

        // Abort mid-sweep with a failure already recorded.
        flip[0] = 8'h01;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_abort_err", 32'(err[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_stim",     32'({b[0], a2[0], a1[0]}), 32'd0);
        check("abort_busy",     32'(busy[0]), 32'd0);
        check("abort_done",     32'(done[0]), 32'd0);
        check("abort_pass",     32'(pass[0]), 32'd0);
        check("abort_err",      32'(err[0]),  32'd0);
        check("abort_fail_idx", 32'(fidx[0]), 32'd0);
        check("abort_fail_vld", 32'(fvld[0]), 32'd0);
        bc = 0;
        dc = 0;
        for (int n = 0; n < 30; n++) begin
            if (busy[0]) bc++;
            if (done[0]) dc++;
            @(negedge clk);
        end
        check("abort_busy_after", 32'(bc), 32'd0);
        check("abort_done_after", 32'(dc), 32'd0);
        run_sweep(0, 8'h00, 1'b0, 3'd0, 1'b0, "post_abort");

        run_sweep(0, 8'h00, 1'b0, 3'd0, 1'b1, "restart_ignored");

        run_sweep(1, 8'h00, 1'b1, 3'd2, 1'b0, "settle1_x2");
        run_sweep(1, 8'h00, 1'b0, 3'd0, 1'b1, "settle1_good");

        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom_range(0, 255));
            run_sweep(0, r, 1'b0, 3'd0, 1'b0, "rand_s2");
            r = 8'($urandom_range(0, 255));
            run_sweep(1, r, 1'b0, 3'd0, ($urandom_range(0, 1) == 1), "rand_s1");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
